// File: rtl/skeleton_sequencer_pkg.sv
// Shared types and constants for the skeletonization sequencer.
// Holds the FSM state encoding, the subiteration phase codes and the frame size helper.
package skel_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_EVAL0 = 3'd2,
    S_WAIT0 = 3'd3,
    S_EVAL1 = 3'd4,
    S_WAIT1 = 3'd5,
    S_WBACK = 3'd6,
    S_DONE  = 3'd7
  } skel_state_t;

  localparam logic PHASE_A = 1'b0;
  localparam logic PHASE_B = 1'b1;

  function automatic int unsigned cells(input int unsigned n);
    return n * n;
  endfunction

endpackage

// File: rtl/skeleton_sequencer_if.sv
// Frame-buffer RAM and mask-array bus driven by the sequencer.
// The master modport is the sequencer side; the slave modport is the memory/array side.
interface skeleton_sequencer_if #(
  parameter int ADDR_W = 7
);

  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rdata;
  logic [7:0]        mem_wdata;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_addr;
  logic [7:0]        arr_wdata;
  logic [7:0]        arr_rdata;
  logic              arr_phase;
  logic              arr_eval;
  logic              arr_eval_done;
  logic              arr_changed;

  modport master (
    output mem_re, mem_we, mem_addr, mem_wdata,
    output arr_we, arr_re, arr_addr, arr_wdata, arr_phase, arr_eval,
    input  mem_rdata, arr_rdata, arr_eval_done, arr_changed
  );

  modport slave (
    input  mem_re, mem_we, mem_addr, mem_wdata,
    input  arr_we, arr_re, arr_addr, arr_wdata, arr_phase, arr_eval,
    output mem_rdata, arr_rdata, arr_eval_done, arr_changed
  );

endinterface

// File: rtl/skeleton_sequencer_addr_counter.sv
// Cell address counter shared by the load and writeback sweeps.
// Provides the issue-side index plus a one-cycle-delayed copy for the commit side.
module skel_addr_counter #(
  parameter int          ADDR_W = 7,
  parameter int unsigned LAST   = 63
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_count,
  output logic              o_last,
  output logic [ADDR_W-1:0] o_dly_count,
  output logic              o_dly_valid
);

  localparam logic [ADDR_W-1:0] LAST_V = ADDR_W'(LAST);
  localparam logic [ADDR_W-1:0] ZERO_V = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_V  = ADDR_W'(1);

  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_dly_count;
  logic              r_last;
  logic              r_dly_valid;
  logic [ADDR_W-1:0] w_count_inc;

  assign w_count_inc = r_count + ONE_V;

  // Issue-side index; parks on LAST so it never wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= ZERO_V;
      r_last  <= 1'b0;
    end else if (i_clear) begin
      r_count <= ZERO_V;
      r_last  <= (LAST_V == ZERO_V);
    end else if (i_en && !r_last) begin
      r_count <= w_count_inc;
      r_last  <= (w_count_inc == LAST_V);
    end else begin
      r_count <= r_count;
      r_last  <= r_last;
    end
  end

  // Commit side trails the issue side by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dly_count <= ZERO_V;
      r_dly_valid <= 1'b0;
    end else begin
      r_dly_valid <= i_en & ~i_clear;
      if (i_en) begin
        r_dly_count <= r_count;
      end else begin
        r_dly_count <= r_dly_count;
      end
    end
  end

  assign o_count     = r_count;
  assign o_last      = r_last;
  assign o_dly_count = r_dly_count;
  assign o_dly_valid = r_dly_valid;

endmodule

// File: rtl/skeleton_sequencer.sv
// Skeletonization controller: loads the frame into the mask array, alternates thinning
// subiterations until a full pass removes nothing (or the pass limit), then writes back.
module skeleton_sequencer
  import skel_pkg::*;
#(
  parameter int N          = 8,
  parameter int ADDR_W     = 7,
  parameter int MAX_PASSES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(MAX_PASSES+1)-1:0]  pass_count,
  output logic                             limit_hit,
  skeleton_sequencer_if.master             bus
);

  localparam int                PW     = $clog2(MAX_PASSES + 1);
  localparam int unsigned       LAST   = cells(N) - 32'd1;
  localparam logic [PW-1:0]     MAXP_V = PW'(MAX_PASSES);
  localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};

  skel_state_t       r_state;
  skel_state_t       w_next;
  logic              r_tail;
  logic              r_chg;
  logic              r_limit;
  logic [PW-1:0]     r_pass;
  logic [PW-1:0]     w_pass_inc;
  logic              w_chg_all;
  logic              w_load;
  logic              w_wback;
  logic              w_issue;
  logic              w_clear;
  logic [ADDR_W-1:0] w_count;
  logic [ADDR_W-1:0] w_dly_count;
  logic              w_last;
  logic              w_dly_valid;
  logic              w_mem_re;
  logic              w_mem_we;
  logic              w_arr_we;
  logic              w_arr_re;

  assign w_load     = (r_state == S_LOAD);
  assign w_wback    = (r_state == S_WBACK);
  assign w_issue    = (w_load | w_wback) & ~r_tail;
  assign w_clear    = (r_state == S_IDLE) | (w_next != r_state);
  assign w_pass_inc = (r_pass == MAXP_V) ? r_pass : r_pass + PW'(1);
  assign w_chg_all  = r_chg | bus.arr_changed;

  skel_addr_counter #(
    .ADDR_W (ADDR_W),
    .LAST   (LAST)
  ) u_addr_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_clear),
    .i_en        (w_issue),
    .o_count     (w_count),
    .o_last      (w_last),
    .o_dly_count (w_dly_count),
    .o_dly_valid (w_dly_valid)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; WAIT1 stops on a quiet pass or when the pass limit is reached
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_LOAD; else w_next = S_IDLE;
      S_LOAD:  if (r_tail) w_next = S_EVAL0; else w_next = S_LOAD;
      S_EVAL0: w_next = S_WAIT0;
      S_WAIT0: if (bus.arr_eval_done) w_next = S_EVAL1; else w_next = S_WAIT0;
      S_EVAL1: w_next = S_WAIT1;
      S_WAIT1: begin
        if (bus.arr_eval_done) begin
          if (!w_chg_all || (w_pass_inc == MAXP_V)) w_next = S_WBACK;
          else w_next = S_EVAL0;
        end else begin
          w_next = S_WAIT1;
        end
      end
      S_WBACK: if (r_tail) w_next = S_DONE; else w_next = S_WBACK;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Tail flag: the extra commit-only cycle after the final issue of a sweep
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail <= 1'b0;
    end else if (w_clear) begin
      r_tail <= 1'b0;
    end else if (w_issue && w_last) begin
      r_tail <= 1'b1;
    end else begin
      r_tail <= r_tail;
    end
  end

  // Pass bookkeeping: change flag, saturating pass count, limit flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chg   <= 1'b0;
      r_pass  <= {PW{1'b0}};
      r_limit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chg   <= 1'b0;
            r_pass  <= {PW{1'b0}};
            r_limit <= 1'b0;
          end
        end
        S_WAIT0: begin
          if (bus.arr_eval_done) r_chg <= bus.arr_changed;
        end
        S_WAIT1: begin
          if (bus.arr_eval_done) begin
            r_chg  <= w_chg_all;
            r_pass <= w_pass_inc;
            if (w_chg_all && (w_pass_inc == MAXP_V)) r_limit <= 1'b1;
          end
        end
        default: begin
          r_chg <= r_chg;
        end
      endcase
    end
  end

  assign w_mem_re = w_load & ~r_tail;
  assign w_arr_we = w_load & w_dly_valid;
  assign w_arr_re = w_wback & ~r_tail;
  assign w_mem_we = w_wback & w_dly_valid;

  assign bus.mem_re    = w_mem_re;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_re ? w_count : (w_mem_we ? w_dly_count : ZERO_A);
  assign bus.mem_wdata = w_mem_we ? bus.arr_rdata : 8'h00;
  assign bus.arr_we    = w_arr_we;
  assign bus.arr_re    = w_arr_re;
  assign bus.arr_addr  = w_arr_re ? w_count : (w_arr_we ? w_dly_count : ZERO_A);
  assign bus.arr_wdata = w_arr_we ? bus.mem_rdata : 8'h00;
  assign bus.arr_phase = ((r_state == S_EVAL1) || (r_state == S_WAIT1)) ? PHASE_B : PHASE_A;
  assign bus.arr_eval  = (r_state == S_EVAL0) || (r_state == S_EVAL1);

  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign pass_count = r_pass;
  assign limit_hit  = r_limit;

endmodule

// File: tb/tb_skeleton_sequencer.sv
// Bench for skeleton_sequencer: frame memory and mask-array models, a bus monitor,
// and a pass-count reference computed directly from the scripted change reports.
module tb_skeleton_sequencer;

  localparam int N      = 4;
  localparam int ADDR_W = 7;
  localparam int MAXP   = 3;
  localparam int PW     = $clog2(MAXP + 1);
  localparam int CELLS  = N * N;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [PW-1:0] pass_count;
  logic          limit_hit;

  skeleton_sequencer_if #(.ADDR_W(ADDR_W)) bus();

  skeleton_sequencer #(.N(N), .ADDR_W(ADDR_W), .MAX_PASSES(MAXP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pass_count (pass_count),
    .limit_hit  (limit_hit),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem     [0:127];
  logic [7:0] arr_m   [0:127];
  logic [7:0] exp_img [0:CELLS-1];
  logic       chg_script [0:5];
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] a_rdata = 8'h00;
  logic       m_eval_done = 1'b0;
  logic       m_changed = 1'b0;
  int         eval_lat = 1;
  int         lat_cnt = 0;
  int         eval_idx = 0;

  assign bus.mem_rdata     = m_rdata;
  assign bus.arr_rdata     = a_rdata;
  assign bus.arr_eval_done = m_eval_done;
  assign bus.arr_changed   = m_changed;

  // Memory and array models; a "changed" report removes one random pixel from the frame
  always @(posedge clk) begin : models
    int  p;
    logic c;
    m_eval_done <= 1'b0;
    m_changed   <= 1'b0;
    if (start && !busy) eval_idx <= 0;
    if (bus.mem_re) m_rdata <= mem[bus.mem_addr];
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.arr_we) arr_m[bus.arr_addr] <= bus.arr_wdata;
    if (bus.arr_re) a_rdata <= arr_m[bus.arr_addr];
    if (!rst_n) begin
      lat_cnt <= 0;
    end else begin
      if (lat_cnt != 0) begin
        lat_cnt <= lat_cnt - 1;
        if (lat_cnt == 1) begin
          c = (eval_idx < 6) ? chg_script[eval_idx] : 1'b1;
          m_eval_done <= 1'b1;
          m_changed   <= c;
          eval_idx    <= eval_idx + 1;
          if (c) begin
            p = $urandom_range(0, CELLS - 1);
            arr_m[p]   <= 8'h00;
            exp_img[p] = 8'h00;
          end
        end
      end
      if (bus.arr_eval) lat_cnt <= eval_lat;
    end
  end

  int n_mem_re, n_mem_we, n_arr_we, n_eval, n_done;
  int excl_err, trail_err, phase_err;
  int cyc, last_we_cyc, done_cyc;
  logic waiting, last_phase, prev_re;
  logic [ADDR_W-1:0] prev_addr;
  logic [ADDR_W-1:0] re_addr_q [$];
  logic [ADDR_W-1:0] we_addr_q [$];
  logic [7:0]        we_data_q [$];

  // Bus monitor sampled on the falling edge
  always @(negedge clk) begin : monitor
    int s;
    if (!rst_n) begin
      prev_re   = 1'b0;
      prev_addr = '0;
      waiting   = 1'b0;
    end else begin
      cyc++;
      if (bus.mem_re) begin n_mem_re++; re_addr_q.push_back(bus.mem_addr); end
      if (bus.mem_we) begin
        n_mem_we++; last_we_cyc = cyc;
        we_addr_q.push_back(bus.mem_addr); we_data_q.push_back(bus.mem_wdata);
      end
      if (bus.arr_we) n_arr_we++;
      if (bus.arr_eval) begin
        if (bus.arr_phase !== n_eval[0]) phase_err++;
        n_eval++; last_phase = bus.arr_phase; waiting = 1'b1;
      end else if (waiting && (bus.arr_phase !== last_phase)) begin
        phase_err++;
      end
      if (m_eval_done) waiting = 1'b0;
      if (done) begin n_done++; done_cyc = cyc; end
      if ((bus.arr_we !== prev_re) || (bus.arr_we && (bus.arr_addr !== prev_addr))) trail_err++;
      s = int'(bus.mem_re) + int'(bus.mem_we) + int'(bus.arr_we) + int'(bus.arr_re) + int'(bus.arr_eval);
      if ((s > 2) || ((s == 2) && !((bus.mem_re && bus.arr_we) || (bus.arr_re && bus.mem_we)))) excl_err++;
      prev_re   = bus.mem_re;
      prev_addr = bus.mem_addr;
    end
  end

  function automatic logic [63:0] outs();
    return {23'd0, busy, done, pass_count, limit_hit, bus.mem_re, bus.mem_we, bus.mem_addr,
            bus.mem_wdata, bus.arr_we, bus.arr_re, bus.arr_addr, bus.arr_wdata,
            bus.arr_phase, bus.arr_eval};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    n_mem_re = 0; n_mem_we = 0; n_arr_we = 0; n_eval = 0; n_done = 0;
    excl_err = 0; trail_err = 0; phase_err = 0;
    last_we_cyc = -100; done_cyc = -200;
    re_addr_q.delete(); we_addr_q.delete(); we_data_q.delete();
  endtask

  // kind: 0 random, 1 ones inside a zero border, 2 ramp mem[k]=k, 3 all ones
  task automatic load_image(input int kind);
    logic [7:0] v;
    for (int k = 0; k < CELLS; k++) begin
      case (kind)
        1:       v = ((k / N > 0) && (k / N < N - 1) && (k % N > 0) && (k % N < N - 1)) ? 8'h01 : 8'h00;
        2:       v = 8'(k);
        3:       v = 8'h01;
        default: v = 8'($urandom_range(0, 255));
      endcase
      mem[k] = v;
      exp_img[k] = v;
    end
  endtask

  // Reference: passes continue while either subiteration reports a change, up to MAXP
  task automatic model_expect(output int ep, output logic el);
    ep = 0;
    el = 1'b0;
    for (int p = 1; p <= MAXP; p++) begin
      ep = p;
      if (!(chg_script[2*p-2] | chg_script[2*p-1])) break;
      if (p == MAXP) el = 1'b1;
    end
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 1000; i++) begin
      if (n_done != 0) break;
      tick();
    end
    checks++;
    if (n_done == 0) begin
      errors++;
      $display("FAIL %s_timeout: no done pulse after %0d cycles, required within 1000", name, i);
    end
    repeat (3) tick();
  endtask

  task automatic run_frame(input string name);
    clear_mon();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(name);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (outs() !== 64'd0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs()); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    checks++;
    if (outs() !== 64'd0) begin errors++; $display("FAIL idle_outputs: got %h required 0", outs()); end
  endtask

  task automatic test_converge();
    int ep; logic el; int bad;
    load_image(1);
    chg_script = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    eval_lat = 2;
    model_expect(ep, el);
    run_frame("converge");
    checks++; if (pass_count !== ep[PW-1:0]) begin errors++; $display("FAIL conv_pass: got %0d required %0d", pass_count, ep); end
    checks++; if (limit_hit !== el) begin errors++; $display("FAIL conv_limit: got %0d required %0d", limit_hit, el); end
    checks++; if (n_mem_re != CELLS || n_mem_we != CELLS) begin errors++; $display("FAIL conv_strobes: got re=%0d we=%0d required %0d each", n_mem_re, n_mem_we, CELLS); end
    checks++; if (done_cyc != last_we_cyc + 1) begin errors++; $display("FAIL conv_done_timing: done at %0d last write %0d", done_cyc, last_we_cyc); end
    checks++; if (n_done != 1) begin errors++; $display("FAIL conv_done_count: got %0d required 1", n_done); end
    checks++; if (n_eval != 2 * ep) begin errors++; $display("FAIL conv_evals: got %0d required %0d", n_eval, 2 * ep); end
    bad = 0;
    for (int k = 0; k < CELLS; k++) if (mem[k] !== exp_img[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL conv_image: got %0d wrong pixels required 0", bad); end
    checks++; if (excl_err != 0) begin errors++; $display("FAIL conv_exclusive: got %0d overlaps required 0", excl_err); end
  endtask

  task automatic test_limit();
    int bad;
    load_image(3);
    for (int i = 0; i < 6; i++) chg_script[i] = 1'b1;
    eval_lat = 1;
    run_frame("limit");
    checks++; if (pass_count !== 2'd3) begin errors++; $display("FAIL limit_pass: got %0d required 3", pass_count); end
    checks++; if (limit_hit !== 1'b1) begin errors++; $display("FAIL limit_flag: got %0d required 1", limit_hit); end
    checks++; if (n_eval != 6) begin errors++; $display("FAIL limit_evals: got %0d required 6", n_eval); end
    bad = 0;
    for (int k = 0; k < CELLS; k++) if (mem[k] !== exp_img[k]) bad++;
    checks++; if (n_mem_we != CELLS || bad != 0) begin errors++; $display("FAIL limit_wback: got %0d writes %0d bad required %0d writes 0 bad", n_mem_we, bad, CELLS); end
  endtask

  task automatic test_start_in_wait0();
    int i; int ep; logic el;
    load_image(0);
    for (int j = 0; j < 6; j++) chg_script[j] = 1'b0;
    eval_lat = 8;
    model_expect(ep, el);
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    for (i = 0; i < 200; i++) begin
      if (n_eval == 1 && waiting && !bus.arr_eval) break;
      tick();
    end
    start = 1'b1; tick(); start = 1'b0;
    wait_done("wait0_start");
    repeat (40) tick();
    checks++; if (n_done != 1) begin errors++; $display("FAIL wait0_done_count: got %0d required 1", n_done); end
    checks++; if (n_mem_re != CELLS || n_eval != 2) begin errors++; $display("FAIL wait0_activity: got re=%0d evals=%0d required %0d and 2", n_mem_re, n_eval, CELLS); end
    checks++; if (pass_count !== ep[PW-1:0] || busy !== 1'b0) begin errors++; $display("FAIL wait0_status: got pass=%0d busy=%0d required %0d and 0", pass_count, busy, ep); end
  endtask

  task automatic test_reset_mid_load();
    int bad;
    load_image(0);
    for (int j = 0; j < 6; j++) chg_script[j] = 1'b0;
    eval_lat = 1;
    clear_mon();
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.mem_re && bus.mem_addr == 7'd5) break;
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++; if (outs() !== 64'd0) begin errors++; $display("FAIL midreset_outputs: got %h required 0", outs()); end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    checks++; if (n_mem_we != 0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_quiet: got writes=%0d busy=%0d required 0", n_mem_we, busy); end
    run_frame("midreset_restart");
    checks++; if (re_addr_q.size() == 0 || re_addr_q[0] !== 7'd0 || n_mem_re != CELLS) begin
      errors++; $display("FAIL midreset_reload: got %0d reads required %0d from address 0", n_mem_re, CELLS);
    end
    bad = 0;
    for (int k = 0; k < CELLS; k++) if (mem[k] !== exp_img[k]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL midreset_image: got %0d wrong pixels required 0", bad); end
  endtask

  task automatic test_echo();
    int bad;
    load_image(2);
    for (int j = 0; j < 6; j++) chg_script[j] = 1'b0;
    eval_lat = 3;
    run_frame("echo");
    bad = 0;
    if (we_addr_q.size() != CELLS || re_addr_q.size() != CELLS) bad = CELLS;
    else for (int k = 0; k < CELLS; k++)
      if (we_addr_q[k] !== ADDR_W'(k) || we_data_q[k] !== 8'(k) || re_addr_q[k] !== ADDR_W'(k)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL echo_writes: got %0d bad entries required 0", bad); end
    checks++; if (trail_err != 0 || n_arr_we != CELLS) begin errors++; $display("FAIL echo_trail: got %0d trail errors %0d loads required 0 and %0d", trail_err, n_arr_we, CELLS); end
    checks++; if (pass_count !== 2'd1 || limit_hit !== 1'b0) begin errors++; $display("FAIL echo_pass: got %0d/%0d required 1/0", pass_count, limit_hit); end
  endtask

  task automatic test_latency10();
    load_image(0);
    for (int j = 0; j < 6; j++) chg_script[j] = 1'b0;
    eval_lat = 10;
    run_frame("lat10");
    checks++; if (phase_err != 0) begin errors++; $display("FAIL lat10_phase: got %0d phase errors required 0", phase_err); end
    checks++; if (pass_count !== 2'd1 || limit_hit !== 1'b0) begin errors++; $display("FAIL lat10_pass: got %0d/%0d required 1/0", pass_count, limit_hit); end
  endtask

  task automatic test_random();
    int ep; logic el; int bad;
    for (int r = 0; r < 8; r++) begin
      load_image(0);
      for (int j = 0; j < 6; j++) chg_script[j] = 1'($urandom_range(0, 1));
      eval_lat = $urandom_range(1, 6);
      model_expect(ep, el);
      run_frame("random");
      bad = 0;
      for (int k = 0; k < CELLS; k++) if (mem[k] !== exp_img[k]) bad++;
      checks++;
      if (pass_count !== ep[PW-1:0] || limit_hit !== el || n_eval != 2 * ep) begin
        errors++; $display("FAIL rand_passes[%0d]: got pass=%0d limit=%0d evals=%0d required %0d/%0d/%0d",
                           r, pass_count, limit_hit, n_eval, ep, el, 2 * ep);
      end
      checks++;
      if (bad != 0 || excl_err != 0 || trail_err != 0 || phase_err != 0) begin
        errors++; $display("FAIL rand_bus[%0d]: got bad=%0d excl=%0d trail=%0d phase=%0d required all 0",
                           r, bad, excl_err, trail_err, phase_err);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 128; k++) begin mem[k] = 8'h00; arr_m[k] = 8'h00; end
    for (int j = 0; j < 6; j++) chg_script[j] = 1'b0;
    clear_mon();
    cyc = 0;
    test_reset();
    test_converge();
    test_limit();
    test_start_in_wait0();
    test_reset_mid_load();
    test_echo();
    test_latency10();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
